// File: rtl/sbox_share_ctrl.sv
// Time-shares NUM_SBOX SubByte lookups between the 128-bit state and 32-bit key-word requesters.
// Result valid 1+chunks cycles after accept; both readys stay low until the granted result is acked.
module sbox_share_ctrl #(
   parameter int NUM_SBOX = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         st_valid_i,
   input  logic [127:0] st_data_i,
   output logic         st_ready_o,
   output logic         st_valid_o,
   output logic [127:0] st_data_o,
   input  logic         st_ack_i,
   input  logic         kw_valid_i,
   input  logic [31:0]  kw_data_i,
   output logic         kw_ready_o,
   output logic         kw_valid_o,
   output logic [31:0]  kw_data_o,
   input  logic         kw_ack_i,
   output logic         busy_o
);

   if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4) begin : g_bad_num_sbox
      $error("sbox_share_ctrl: NUM_SBOX must be 1, 2 or 4");
   end

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam logic [3:0] ST_LAST = 4'(16 / NUM_SBOX - 1);
   localparam logic [3:0] KW_LAST = 4'(4 / NUM_SBOX - 1);

   // Entry for byte x sits at index 255-x (= ~x) so the rows read in the usual table order.
   localparam logic [255:0][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   logic [1:0]   state_q, state_d;
   logic [127:0] buf_q, buf_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         grant_q, grant_d;
   logic         last_grant_q, last_grant_d;
   logic         win_kw;

   // Round-robin on a tie: the requester that was not granted last time wins.
   assign win_kw     = kw_valid_i & (~st_valid_i | ~last_grant_q);
   assign st_ready_o = ~rst_i & (state_q == IDLE) & st_valid_i & ~win_kw;
   assign kw_ready_o = ~rst_i & (state_q == IDLE) & win_kw;

   always_comb begin
      state_d      = state_q;
      buf_d        = buf_q;
      cnt_d        = cnt_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      case (state_q)
         IDLE: begin
            if (st_ready_o) begin
               buf_d        = st_data_i;
               grant_d      = 1'b0;
               last_grant_d = 1'b0;
               cnt_d        = 4'd0;
               state_d      = BUSY;
            end else if (kw_ready_o) begin
               buf_d        = {96'd0, kw_data_i};
               grant_d      = 1'b1;
               last_grant_d = 1'b1;
               cnt_d        = 4'd0;
               state_d      = BUSY;
            end
         end
         BUSY: begin
            for (int i = 0; i < NUM_SBOX; i++) begin
               buf_d[8*(int'(cnt_q)*NUM_SBOX + i) +: 8] =
                  SBOX[~buf_q[8*(int'(cnt_q)*NUM_SBOX + i) +: 8]];
            end
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == (grant_q ? KW_LAST : ST_LAST)) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (grant_q ? kw_ack_i : st_ack_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= IDLE;
         buf_q        <= '0;
         cnt_q        <= '0;
         grant_q      <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         buf_q        <= buf_d;
         cnt_q        <= cnt_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign st_valid_o = (state_q == DONE) & ~grant_q;
   assign kw_valid_o = (state_q == DONE) & grant_q;
   assign st_data_o  = buf_q;
   assign kw_data_o  = buf_q[31:0];
   assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Bench for sbox_share_ctrl: three instances (NUM_SBOX = 4, 2, 1) checked against a GF(2^8) S-box model.
// Expected results are queued at accept time and compared when the matching valid_o rises.
module tb_sbox_share_ctrl;

   logic clk;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic         st_vi  [3];
   logic [127:0] st_di  [3];
   logic         st_ro  [3];
   logic         st_vo  [3];
   logic [127:0] st_do  [3];
   logic         st_ack [3];
   logic         kw_vi  [3];
   logic [31:0]  kw_di  [3];
   logic         kw_ro  [3];
   logic         kw_vo  [3];
   logic [31:0]  kw_do  [3];
   logic         kw_ack [3];
   logic         busy   [3];

   logic [127:0] st_exp [$];
   logic [31:0]  kw_exp [$];

   for (genvar g = 0; g < 3; g++) begin : g_dut
      sbox_share_ctrl #(.NUM_SBOX(g == 0 ? 4 : (g == 1 ? 2 : 1))) u_dut (
         .clk_i      (clk),
         .rst_i      (rst),
         .st_valid_i (st_vi[g]),
         .st_data_i  (st_di[g]),
         .st_ready_o (st_ro[g]),
         .st_valid_o (st_vo[g]),
         .st_data_o  (st_do[g]),
         .st_ack_i   (st_ack[g]),
         .kw_valid_i (kw_vi[g]),
         .kw_data_i  (kw_di[g]),
         .kw_ready_o (kw_ro[g]),
         .kw_valid_o (kw_vo[g]),
         .kw_data_o  (kw_do[g]),
         .kw_ack_i   (kw_ack[g]),
         .busy_o     (busy[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox_m(input logic [7:0] x);
      logic [7:0] b = 8'h00;
      for (int y = 1; y < 256; y++) begin
         if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) b = 8'(y);
      end
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_all(input logic [127:0] v);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_m(v[8*i +: 8]);
      return r;
   endfunction

   function automatic int nsb(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 2 : 1);
   endfunction

   // Present a request, wait (bounded) for ready, drop valid after the accept edge.
   task automatic request(input int d, input bit kw, input logic [127:0] data,
                          input logic [127:0] exp, output int acc);
      bit ok = 1'b0;
      if (kw) begin kw_di[d] = data[31:0]; kw_vi[d] = 1'b1; end
      else    begin st_di[d] = data;       st_vi[d] = 1'b1; end
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (kw ? kw_ro[d] : st_ro[d]) begin ok = 1'b1; break; end
      end
      @(posedge clk);
      #1;
      acc = cyc;
      if (kw) kw_vi[d] = 1'b0; else st_vi[d] = 1'b0;
      if (ok) begin
         if (kw) kw_exp.push_back(exp[31:0]); else st_exp.push_back(exp);
      end else begin
         checks++; errors++;
         $display("FAIL accept_timeout dut=%0d kw=%0d ready never seen within 60 cycles", d, kw);
      end
   endtask

   // Wait for the result, check latency and data against the scoreboard, then ack it.
   task automatic collect(input int d, input bit kw, input int exp_lat, input int acc,
                          output int ack_cyc);
      bit ok = 1'b0;
      int lat;
      logic [127:0] e;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (kw ? kw_vo[d] : st_vo[d]) begin ok = 1'b1; break; end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL result_timeout dut=%0d kw=%0d valid_o never seen within 60 cycles", d, kw);
      end else begin
         lat = cyc - acc + 1;
         checks++;
         if (lat !== exp_lat) begin
            errors++;
            $display("FAIL latency dut=%0d kw=%0d got T+%0d expected T+%0d", d, kw, lat, exp_lat);
         end
         checks++;
         if ((kw ? st_vo[d] : kw_vo[d]) !== 1'b0) begin
            errors++;
            $display("FAIL other_valid dut=%0d kw=%0d other valid_o high, expected 0", d, kw);
         end
      end
      checks++;
      if ((kw ? kw_exp.size() : st_exp.size()) == 0) begin
         errors++;
         $display("FAIL scoreboard_empty dut=%0d kw=%0d no expected entry", d, kw);
      end else if (kw) begin
         e = {96'd0, kw_exp.pop_front()};
         if (kw_do[d] !== e[31:0]) begin
            errors++;
            $display("FAIL kw_data dut=%0d got %h expected %h", d, kw_do[d], e[31:0]);
         end
      end else begin
         e = st_exp.pop_front();
         if (st_do[d] !== e) begin
            errors++;
            $display("FAIL st_data dut=%0d got %h expected %h", d, st_do[d], e);
         end
      end
      @(posedge clk);
      #1;
      if (kw) kw_ack[d] = 1'b1; else st_ack[d] = 1'b1;
      @(posedge clk);
      #1;
      ack_cyc = cyc;
      kw_ack[d] = 1'b0;
      st_ack[d] = 1'b0;
   endtask

   task automatic test_reset();
      for (int d = 0; d < 3; d++) begin st_vi[d] = 1'b1; kw_vi[d] = 1'b1; end
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({st_ro[d], st_vo[d], kw_ro[d], kw_vo[d], busy[d]} !== 5'b0 ||
             st_do[d] !== 128'd0 || kw_do[d] !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs dut=%0d ctrl=%b st_do=%h kw_do=%h expected all 0", d,
                     {st_ro[d], st_vo[d], kw_ro[d], kw_vo[d], busy[d]}, st_do[d], kw_do[d]);
         end
      end
      for (int d = 0; d < 3; d++) begin st_vi[d] = 1'b0; kw_vi[d] = 1'b0; end
      rst = 1'b0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         checks++;
         if ({st_ro[d], st_vo[d], kw_ro[d], kw_vo[d], busy[d]} !== 5'b0) begin
            errors++;
            $display("FAIL post_reset_outputs dut=%0d ctrl=%b expected 00000", d,
                     {st_ro[d], st_vo[d], kw_ro[d], kw_vo[d], busy[d]});
         end
      end
   endtask

   task automatic test_vectors(input int d);
      int acc, ak;
      int sl = 1 + 16 / nsb(d);
      int kl = 1 + 4 / nsb(d);
      logic [127:0] r;
      logic [31:0]  k;
      request(d, 1'b0, 128'h00112233445566778899aabbccddeeff,
              128'h638293c31bfc33f5c4eeacea4bc12816, acc);
      collect(d, 1'b0, sl, acc, ak);
      request(d, 1'b1, 128'h1, 128'h6363637c, acc);
      collect(d, 1'b1, kl, acc, ak);
      r = {$urandom, $urandom, $urandom, $urandom};
      request(d, 1'b0, r, sub_all(r), acc);
      collect(d, 1'b0, sl, acc, ak);
      k = $urandom;
      request(d, 1'b1, {96'd0, k}, sub_all({96'd0, k}), acc);
      collect(d, 1'b1, kl, acc, ak);
   endtask

   task automatic test_arbitration();
      int acc, ak;
      int last_ak = 0;
      bit ok;
      bit exp_kw;
      rst = 1'b1;
      st_di[0] = {$urandom, $urandom, $urandom, $urandom};
      kw_di[0] = $urandom;
      st_vi[0] = 1'b1;
      kw_vi[0] = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int t = 0; t < 4; t++) begin
         exp_kw = (t % 2) == 1;
         ok = 1'b0;
         for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (st_ro[0] || kw_ro[0]) begin ok = 1'b1; break; end
         end
         checks++;
         if (!ok || kw_ro[0] !== exp_kw || st_ro[0] !== !exp_kw) begin
            errors++;
            $display("FAIL arb_grant t=%0d st_ready=%b kw_ready=%b expected kw winner=%0d", t,
                     st_ro[0], kw_ro[0], exp_kw);
         end
         @(posedge clk);
         #1;
         acc = cyc;
         if (t > 0) begin
            checks++;
            if (acc !== last_ak + 1) begin
               errors++;
               $display("FAIL arb_accept_after_ack t=%0d accept at %0d expected %0d", t, acc, last_ak + 1);
            end
         end
         if (kw_ro[0] === 1'b0 && st_ro[0] === 1'b0 && ok) begin
            if (exp_kw) begin
               kw_exp.push_back(sub_all({96'd0, kw_di[0]}) & 32'hffffffff);
               kw_di[0] = $urandom;
            end else begin
               st_exp.push_back(sub_all(st_di[0]));
               st_di[0] = {$urandom, $urandom, $urandom, $urandom};
            end
         end
         collect(0, exp_kw, exp_kw ? 2 : 5, acc, ak);
         last_ak = ak;
      end
      st_vi[0] = 1'b0;
      kw_vi[0] = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_hold();
      int acc, ak;
      bit ok = 1'b0;
      logic [127:0] v = {$urandom, $urandom, $urandom, $urandom};
      logic [127:0] e = sub_all(v);
      logic [31:0]  k = $urandom;
      request(0, 1'b0, v, e, acc);
      kw_di[0] = k;
      kw_vi[0] = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (st_vo[0]) begin ok = 1'b1; break; end
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         kw_ack[0] = ~kw_ack[0];
         @(negedge clk);
         checks++;
         if (!ok || st_vo[0] !== 1'b1 || st_do[0] !== e || st_ro[0] !== 1'b0 ||
             kw_ro[0] !== 1'b0 || kw_vo[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold c=%0d st_vo=%b st_do=%h st_ro=%b kw_ro=%b kw_vo=%b expected 1 %h 0 0 0",
                     c, st_vo[0], st_do[0], st_ro[0], kw_ro[0], kw_vo[0], e);
         end
      end
      @(posedge clk);
      #1;
      kw_ack[0] = 1'b0;
      collect(0, 1'b0, 1 + acc - acc + (cyc - acc), acc, ak);
      ok = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (kw_ro[0]) begin ok = 1'b1; break; end
      end
      @(posedge clk);
      #1;
      acc = cyc;
      kw_vi[0] = 1'b0;
      checks++;
      if (!ok || acc !== ak + 1) begin
         errors++;
         $display("FAIL pending_kw accept at %0d ok=%0d expected %0d", acc, ok, ak + 1);
      end
      kw_exp.push_back(sub_all({96'd0, k}) & 32'hffffffff);
      collect(0, 1'b1, 2, acc, ak);
   endtask

   task automatic test_reset_mid();
      int acc, ak;
      logic [127:0] v = {$urandom, $urandom, $urandom, $urandom};
      request(0, 1'b0, v, sub_all(v), acc);
      #2;
      checks++;
      if (busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL busy_in_busy got %b expected 1", busy[0]);
      end
      rst = 1'b1;
      #1;
      checks++;
      if ({st_ro[0], st_vo[0], kw_ro[0], kw_vo[0], busy[0]} !== 5'b0 ||
          st_do[0] !== 128'd0 || kw_do[0] !== 32'd0) begin
         errors++;
         $display("FAIL mid_reset ctrl=%b st_do=%h kw_do=%h expected all 0",
                  {st_ro[0], st_vo[0], kw_ro[0], kw_vo[0], busy[0]}, st_do[0], kw_do[0]);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      st_exp.delete();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++;
         if (st_vo[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL discarded c=%0d st_vo=%b busy=%b expected 0 0", c, st_vo[0], busy[0]);
         end
      end
      @(posedge clk);
      #1;
      request(0, 1'b1, 128'hffffffff, 128'h16161616, acc);
      collect(0, 1'b1, 2, acc, ak);
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 3; d++) begin
         st_vi[d] = 1'b0; st_di[d] = '0; st_ack[d] = 1'b0;
         kw_vi[d] = 1'b0; kw_di[d] = '0; kw_ack[d] = 1'b0;
      end
      test_reset();
      for (int d = 0; d < 3; d++) test_vectors(d);
      test_arbitration();
      test_hold();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
